// File: rtl/vga_line_fetch_if.sv
// Framebuffer read port between the line fetcher (master) and memory (slave).
// mem_req/mem_ack: master holds mem_req high with mem_addr stable until mem_ack; mem_data is taken on the ack cycle.
interface vga_line_fetch_if;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;

    modport master (output mem_req, mem_addr, input mem_ack, mem_data);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/vga_line_fetch.sv
// Ping-pong line fetcher: fills one line buffer from the framebuffer while the
// other is scanned out 2x scaled to a 640x480 VGA driver.
module vga_line_fetch #(
    parameter int SRC_W = 320,
    parameter int SRC_H = 240
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [9:0]            next_x,
    input  logic [9:0]            next_y,
    output logic [7:0]            color_out,
    vga_line_fetch_if.master      mem,
    output logic                  underrun,
    output logic [1:0]            fsm_state_dbg
);

    localparam int COL_W = $clog2(SRC_W);
    localparam int ROW_W = $clog2(SRC_H);
    localparam logic [9:0] VIS_W       = 10'd640;
    localparam logic [9:0] VIS_H       = 10'd480;
    localparam logic [9:0] X_LAST      = 10'd799;
    localparam logic [9:0] Y_PRE       = 10'd523;
    localparam logic [9:0] Y_LAST      = 10'd524;
    localparam logic [9:0] LAST_TRIG_Y = 10'(2 * SRC_H - 4);
    localparam logic [9:0] LAST_SWAP_Y = 10'(2 * SRC_H - 3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               disp_bank_q, disp_bank_d;
    logic               frame_valid_q, frame_valid_d;
    logic               underrun_q, underrun_d;
    logic               wr_en;
    logic               trigger;
    logic               swap;
    logic [ROW_W-1:0]   fetch_row;
    logic [COL_W-1:0]   rd_col;

    // Line buffer contents are deliberately left unreset.
    logic [7:0] line_buf_q [2][SRC_W];

    // Fetch on even lines ahead of the pair that shows the row; y=523 preloads row 0.
    assign trigger = (next_x == 10'd0) &&
                     ((!next_y[0] && next_y <= LAST_TRIG_Y) || next_y == Y_PRE);
    assign swap    = (next_x == X_LAST) &&
                     ((next_y[0] && next_y <= LAST_SWAP_Y) || next_y == Y_LAST);
    assign fetch_row = (next_y == Y_PRE) ? '0 : ROW_W'((next_y >> 1) + 10'd1);

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        disp_bank_d   = disp_bank_q;
        frame_valid_d = frame_valid_q;
        underrun_d    = underrun_q;
        wr_en         = 1'b0;
        if (swap) begin
            disp_bank_d   = ~disp_bank_q;
            frame_valid_d = 1'b1;
            if (state_q != DONE) underrun_d = 1'b1;
            state_d       = IDLE;
        end else if (trigger) begin
            if (state_q == REQ) underrun_d = 1'b1;
            state_d = REQ;
            col_d   = '0;
            row_d   = fetch_row;
        end else if (state_q == REQ && mem.mem_ack) begin
            wr_en = 1'b1;
            if (col_q == COL_W'(SRC_W - 1)) state_d = DONE;
            else                             col_d   = col_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            disp_bank_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            disp_bank_q   <= disp_bank_d;
            frame_valid_q <= frame_valid_d;
            underrun_q    <= underrun_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) line_buf_q[~disp_bank_q][col_q] <= mem.mem_data;
    end

    assign rd_col = COL_W'(next_x >> 1);

    always_comb begin
        color_out = '0;
        if (frame_valid_q && next_x < VIS_W && next_y < VIS_H)
            color_out = line_buf_q[disp_bank_q][rd_col];
    end

    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_addr  = 17'(row_q) * 17'(SRC_W) + 17'(col_q);
    assign underrun      = underrun_q;
    assign fsm_state_dbg = state_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: skips through selected VGA lines against a
// procedural framebuffer model with zero-wait, 3-cycle-latency and stalled memory.
module tb_vga_line_fetch;

  logic       clock;
  logic       reset;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic [7:0] color_out;
  logic       underrun;
  logic [1:0] fsm_state_dbg;
  int         mem_mode;
  int         lat_cnt;
  int         n_checks;
  int         n_pass;

  vga_line_fetch_if mif ();

  vga_line_fetch #(.SRC_W(320), .SRC_H(240)) dut (
    .clock         (clock),
    .reset         (reset),
    .next_x        (next_x),
    .next_y        (next_y),
    .color_out     (color_out),
    .mem           (mif),
    .underrun      (underrun),
    .fsm_state_dbg (fsm_state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #20 clock = ~clock;
  end

  // framebuffer model: mode 0 zero-wait, 1 ack on 4th request cycle, 2 never acks
  function automatic logic [7:0] mem_f(input logic [16:0] a);
    return a[7:0] ^ {1'b0, a[16:10]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] exp_pix(input int x, input int y);
    logic [16:0] a;
    if (x >= 640 || y >= 480) return 8'h00;
    a = 17'((y >> 1) * 320 + (x >> 1));
    return mem_f(a);
  endfunction

  assign mif.mem_data = mem_f(mif.mem_addr);
  assign mif.mem_ack  = (mem_mode == 0) ? mif.mem_req :
                        (mem_mode == 1) ? (mif.mem_req && lat_cnt == 3) : 1'b0;

  always @(posedge clock) begin
    if (!mif.mem_req || mif.mem_ack) lat_cnt <= 0;
    else                             lat_cnt <= lat_cnt + 1;
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // driver tasks
  task automatic drive(input int x, input int y);
    @(negedge clock);
    next_x = 10'(x);
    next_y = 10'(y);
    #1;
  endtask

  task automatic run_span(input int y, input int x0, input int x1, input bit chk);
    for (int x = x0; x <= x1; x++) begin
      drive(x, y);
      if (chk && ((x % 41) == 0 || (x >= 638 && x <= 641) || x == 799))
        check($sformatf("pix_x%0d_y%0d", x, y), color_out, exp_pix(x, y));
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mem_mode = 0;
    lat_cnt  = 0;
    reset    = 1'b1;
    next_x   = 10'd0;
    next_y   = 10'd500;

    // reset state, seen before any clock edge
    #2 reset = 1'b0;
    #3;
    check("rst_req", mif.mem_req, 1'b0);
    check("rst_addr", mif.mem_addr, 17'd0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_color", color_out, 8'd0);
    check("rst_state", fsm_state_dbg, 2'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // zero-wait memory: preload row 0, then lines 0..3
    drive(0, 523);
    drive(1, 523);
    check("zw_req", mif.mem_req, 1'b1);
    check("zw_addr0", mif.mem_addr, 17'd0);
    drive(2, 523);
    check("zw_addr1", mif.mem_addr, 17'd1);
    run_span(523, 3, 319, 1'b0);
    drive(320, 523);
    check("zw_addr319", mif.mem_addr, 17'd319);
    drive(321, 523);
    check("zw_req_done", mif.mem_req, 1'b0);
    check("zw_state_done", fsm_state_dbg, 2'd2);
    run_span(523, 322, 799, 1'b0);
    run_span(524, 0, 799, 1'b0);
    run_span(0, 0, 799, 1'b1);
    run_span(1, 0, 799, 1'b1);
    run_span(2, 0, 799, 1'b1);
    run_span(3, 0, 799, 1'b1);
    run_span(20, 0, 799, 1'b0);
    run_span(21, 0, 799, 1'b0);
    run_span(22, 0, 799, 1'b1);
    check("zw_underrun", underrun, 1'b0);

    // 3-cycle ack latency: row 16 fetched at y=30, done after 1280 cycles
    mem_mode = 1;
    run_span(30, 0, 4, 1'b0);
    drive(5, 30);
    check("lat_addr", mif.mem_addr, 17'd5121);
    run_span(30, 6, 799, 1'b0);
    run_span(31, 0, 479, 1'b0);
    drive(480, 31);
    check("lat_req_last", mif.mem_req, 1'b1);
    drive(481, 31);
    check("lat_req_done", mif.mem_req, 1'b0);
    check("lat_state_done", fsm_state_dbg, 2'd2);
    run_span(31, 482, 799, 1'b0);
    run_span(32, 0, 799, 1'b1);
    run_span(33, 0, 799, 1'b1);
    check("lat_underrun", underrun, 1'b0);

    // stalled memory: trigger at y=10 never completes
    mem_mode = 2;
    drive(0, 10);
    drive(1, 10);
    check("stall_req", mif.mem_req, 1'b1);
    check("stall_addr", mif.mem_addr, 17'd1920);
    run_span(10, 2, 799, 1'b0);
    run_span(11, 0, 798, 1'b0);
    drive(799, 11);
    check("stall_req_hold", mif.mem_req, 1'b1);
    check("stall_addr_hold", mif.mem_addr, 17'd1920);
    check("stall_underrun_pre", underrun, 1'b0);
    mem_mode = 0;
    drive(0, 12);
    check("stall_req_drop", mif.mem_req, 1'b0);
    check("stall_underrun", underrun, 1'b1);
    run_span(12, 1, 400, 1'b0);
    check("stall_underrun_sticky", underrun, 1'b1);

    // reset mid-fetch, released during vertical blanking
    mem_mode = 1;
    run_span(40, 0, 100, 1'b0);
    check("mid_req_pre", mif.mem_req, 1'b1);
    #5 reset = 1'b0;
    #1;
    check("mid_req", mif.mem_req, 1'b0);
    check("mid_addr", mif.mem_addr, 17'd0);
    check("mid_color", color_out, 8'd0);
    check("mid_underrun", underrun, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b1;
    next_x = 10'd10;
    next_y = 10'd100;
    #1;
    check("post_rst_color", color_out, 8'd0);
    check("post_rst_req", mif.mem_req, 1'b0);
    mem_mode = 0;
    drive(11, 100);
    check("post_rst_color2", color_out, 8'd0);
    check("post_rst_req2", mif.mem_req, 1'b0);
    run_span(500, 0, 799, 1'b0);
    run_span(523, 0, 799, 1'b0);
    run_span(524, 0, 799, 1'b0);
    run_span(0, 0, 799, 1'b1);
    check("post_rst_underrun", underrun, 1'b0);

    // last source row: y=476 fetches 76480..76799, no trigger at y=478
    drive(0, 476);
    drive(1, 476);
    check("last_addr_first", mif.mem_addr, 17'd76480);
    run_span(476, 2, 319, 1'b0);
    drive(320, 476);
    check("last_addr_max", mif.mem_addr, 17'd76799);
    drive(321, 476);
    check("last_req_done", mif.mem_req, 1'b0);
    run_span(476, 322, 799, 1'b0);
    run_span(477, 0, 799, 1'b0);
    drive(0, 478);
    drive(1, 478);
    check("no_trig_478", mif.mem_req, 1'b0);
    run_span(478, 2, 799, 1'b1);
    run_span(479, 0, 799, 1'b1);
    check("final_underrun", underrun, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SHALL have parameters: SRC_W, default 320, source pixels per row; SRC_H, default 240, source rows per frame.
REQ-002 SHALL have port clock, input, 1, 25 MHz pixel clock, same clock as the VGA driver.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port next_x, input, 10, driver horizontal count (0..799).
REQ-005 SHALL have port next_y, input, 10, driver vertical count (0..524).
REQ-006 SHALL have port color_out, output, 8, RRRGGGBB pixel fed to the driver color_in.
REQ-007 SHALL have port mem_req, output, 1, framebuffer read request.
REQ-008 SHALL have port mem_addr, output, 17, framebuffer word address (row*SRC_W + col).
REQ-009 SHALL have port mem_ack, input, 1, read accepted; mem_data is valid in the same cycle.
REQ-010 SHALL have port mem_data, input, 8, read data.
REQ-011 SHALL have port underrun, output, 1, sticky flag: a row fetch was incomplete at its swap point.

Function
REQ-012 SHALL hold two line buffers, each SRC_W x 8 bits (ping-pong), with a disp_bank select bit; the fill bank is ~disp_bank.
REQ-013 SHALL drive color_out combinationally as buf[disp_bank][next_x>>1] when next_x<640, next_y<480 and frame_valid=1; otherwise color_out SHALL be 0.
REQ-014 SHALL generate a fetch trigger when next_x==0 and either (next_y even and next_y<=476) or next_y==523.
REQ-015 SHALL set the fetch row to 0 when next_y==523; otherwise it SHALL be (next_y>>1)+1.
REQ-016 SHALL generate a swap event when next_x==799 and either (next_y odd and next_y<=477) or next_y==524.
REQ-017 SHALL use the FSM states IDLE, REQ and DONE.
REQ-018 SHALL transition IDLE->REQ on a trigger, with col=0 and mem_req asserted from the next cycle.
REQ-019 SHALL, in REQ, hold mem_req=1 and mem_addr stable until mem_ack.
REQ-020 SHALL, on mem_ack, write mem_data into the fill bank at col and increment col.
REQ-021 SHALL, when col reaches SRC_W-1 and mem_ack is seen, move to DONE and deassert mem_req in the next cycle.
REQ-022 SHALL otherwise, on mem_ack, present the next address in the next cycle with mem_req held high, allowing back-to-back acks.
REQ-023 SHALL keep only one request outstanding and SHALL ignore mem_ack while in IDLE or DONE.
REQ-024 SHALL, on a swap event, toggle disp_bank, set frame_valid=1 and return the FSM to IDLE.
REQ-025 SHALL set underrun=1 if a swap event occurs while the FSM is not in DONE.
REQ-026 SHALL, on such an incomplete swap, still toggle disp_bank and abort the fetch: mem_req=0 the next cycle and no further writes.
REQ-027 SHALL, if a trigger and a swap coincide, give the swap priority (these events cannot coincide under legal counts).
REQ-028 SHALL, if a trigger arrives while in REQ, abort the current fetch, set underrun=1 and restart at col=0 for the new row.
REQ-029 SHALL compute mem_addr as row*SRC_W+col in 17 bits; its maximum of 76799 SHALL never wrap.

Reset
REQ-030 SHALL, while reset=0, force immediately: FSM=IDLE, mem_req=0, mem_addr=0, col=0, row=0, disp_bank=0, frame_valid=0, underrun=0.
REQ-031 SHALL output color_out=0 during reset and until the first swap event; line-buffer contents SHALL NOT be reset.
REQ-032 SHALL take reset deassertion synchronously to clock and honour no trigger earlier than the first clock edge after release.
REQ-033 SHALL, on reset mid-fetch, drop mem_req within the reset assertion; there SHALL be no resumption afterwards.

Verification
REQ-034 SHALL cover this case: zero-wait memory (mem_ack=mem_req) over a full frame -> row r appears on lines 2r and 2r+1; pixel (x,y) equals mem[(y>>1)*320+(x>>1)]; underrun stays 0.
REQ-035 SHALL cover this case: 3-cycle ack latency -> fetch completes in 1280 cycles, before the swap at 1599 cycles; output is identical to REQ-034.
REQ-036 SHALL cover this case: mem_ack held 0 after a trigger at next_y=10 -> mem_req stays high with mem_addr=6*320=1920; at next_y=11, x=799 underrun=1, banks swap and mem_req=0 the next cycle.
REQ-037 SHALL cover this case: reset pulled low with mem_req=1 mid-row -> mem_req=0 and color_out=0 without a clock edge; after release, the first nonzero color_out appears only at next_y=0 after the y=524 swap.
REQ-038 SHALL cover this case: blanking region next_x=640..799 or next_y>=480 with nonzero buffers -> color_out=0.
REQ-039 SHALL cover this case: the last row -> the trigger at y=476 fetches addresses 76480..76799; no trigger occurs at y=478.
